// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the bit-counter width helper.
package serial_arith_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell and a
// borrow flop; start/busy/done handshake with a held registered result.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r, state_n;
    logic [WIDTH-1:0] a_r, a_n, b_r, b_n, res_r, res_n, diff_r, diff_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic             br_r, br_n, bout_r, bout_n, done_r, done_n;
    logic             d_s, br_next_s;
    logic [WIDTH:0]   res_cat_s;

    full_subtractor_bit u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (br_next_s)
    );

    // New bit enters from the MSB side; this form also holds for WIDTH == 1.
    assign res_cat_s = {d_s, res_r};

    // Next-state, datapath and output logic.
    always_comb begin
        state_n = state_r;
        a_n     = a_r;
        b_n     = b_r;
        res_n   = res_r;
        br_n    = br_r;
        cnt_n   = cnt_r;
        diff_n  = diff_r;
        bout_n  = bout_r;
        done_n  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    br_n    = bin;
                    res_n   = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                a_n   = a_r >> 1'b1;
                b_n   = b_r >> 1'b1;
                res_n = res_cat_s[WIDTH:1];
                br_n  = br_next_s;
                if (cnt_r == LAST_CNT) begin
                    diff_n  = res_cat_s[WIDTH:1];
                    bout_n  = br_next_s;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n   = cnt_r + CW'(1'b1);
                    state_n = SHIFT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, operand, borrow, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            diff_r  <= '0;
            bout_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            a_r     <= a_n;
            b_r     <= b_n;
            res_r   <= res_n;
            br_r    <= br_n;
            cnt_r   <= cnt_n;
            diff_r  <= diff_n;
            bout_r  <= bout_n;
            done_r  <= done_n;
        end
    end

    assign busy = (state_r == SHIFT);
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8, 4 and 1: directed cases,
// randomized traffic and exhaustive coverage of the narrow instances.
module tb_serial_subtractor;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] st;
    logic [2:0] bi;
    logic [2:0] acc;
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic       bsy0, bsy1, bsy2, dn0, dn1, dn2, bo0, bo1, bo2;
    logic [7:0] df8;
    logic [3:0] df4;
    logic [0:0] df1;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         wd [3];
    int         last_e0 [3];
    int         free_e [3];
    logic [7:0] hold_d [3];
    logic       hold_b [3];
    exp_t       q0 [$];
    exp_t       q1 [$];
    exp_t       q2 [$];

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .bin(bi[0]),
        .busy(bsy0), .done(dn0), .diff(df8), .bout(bo0)
    );
    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]), .bin(bi[1]),
        .busy(bsy1), .done(dn1), .diff(df4), .bout(bo1)
    );
    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][0:0]), .b(bv[2][0:0]), .bin(bi[2]),
        .busy(bsy2), .done(dn2), .diff(df1), .bout(bo2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int qsize(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int u);
        case (u)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int u);
        case (u)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(input int u, input exp_t e);
        case (u)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s w%0d cyc=%0d got=%0h expected=%0h", nm, wd[u], cyc, act, exp);
        end
    endtask

    // Forget everything in flight: reset aborts operations without a done.
    task automatic flush_model();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int u = 0; u < 3; u++) begin
            last_e0[u] = -1000;
            free_e[u]  = 0;
            hold_d[u]  = 8'h00;
            hold_b[u]  = 1'b0;
        end
    endtask

    // Reference model: start is taken only when the unit is idle at the sampling edge.
    task automatic tick();
        exp_t e;
        int   msk, r;
        for (int u = 0; u < 3; u++) begin
            acc[u] = 1'b0;
            if (st[u] && rst_n && (cyc + 1 >= free_e[u])) begin
                msk   = (1 << wd[u]) - 1;
                r     = (int'(av[u]) & msk) - (int'(bv[u]) & msk) - int'(bi[u]);
                e.cyc = cyc + 1 + wd[u];
                e.d   = 8'(r & msk);
                e.b   = (r < 0);
                qpush(u, e);
                last_e0[u] = cyc + 1;
                free_e[u]  = cyc + 2 + wd[u];
                acc[u]     = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int u, input logic bsy_o, input logic dn_o, input logic [7:0] df_o, input logic bo_o);
        exp_t e;
        chk("busy", u, {31'b0, bsy_o}, {31'b0, (cyc >= last_e0[u]) && (cyc < last_e0[u] + wd[u])});
        if (dn_o) begin
            if (qsize(u) == 0) begin
                chk("spurious_done", u, 32'd1, 32'd0);
            end else begin
                e = qfront(u);
                qpop(u);
                chk("done_cycle", u, cyc, e.cyc);
                hold_d[u] = e.d;
                hold_b[u] = e.b;
            end
        end else if (qsize(u) != 0) begin
            e = qfront(u);
            if (e.cyc <= cyc) begin
                chk("missed_done", u, 32'd0, 32'd1);
                qpop(u);
            end
        end
        chk("diff", u, {24'b0, df_o}, {24'b0, hold_d[u]});
        chk("bout", u, {31'b0, bo_o}, {31'b0, hold_b[u]});
    endtask

    always @(negedge clk) begin
        mon(0, bsy0, dn0, df8, bo0);
        mon(1, bsy1, dn1, {4'b0, df4}, bo1);
        mon(2, bsy2, dn2, {7'b0, df1}, bo2);
    end

    task automatic wait_idle();
        for (int k = 0; k < 40 && (cyc + 1 < free_e[0]); k++) tick();
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
        av[0] = x;
        bv[0] = y;
        bi[0] = c;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int   i1, i2;
        logic iss1, iss2;
        wd[0] = 8;
        wd[1] = 4;
        wd[2] = 1;
        flush_model();
        rst_n = 1'b0;
        st    = 3'b000;
        bi    = 3'b000;
        acc   = 3'b000;
        for (int u = 0; u < 3; u++) begin
            av[u] = 8'h00;
            bv[u] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        op8(8'h5A, 8'h23, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'h10, 8'h10, 1'b1);

        // A start pulse mid-run must not disturb the operation in flight.
        av[0] = 8'h80; bv[0] = 8'h01; bi[0] = 1'b0; st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        tick();
        tick();
        av[0] = 8'hFF; bv[0] = 8'hFF; st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        wait_idle();

        // Start held high across done: the second operation starts immediately.
        av[0] = 8'h0F; bv[0] = 8'h0E; bi[0] = 1'b0; st[0] = 1'b1;
        tick();
        av[0] = 8'h01; bv[0] = 8'h02;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (acc[0]) break;
        end
        st[0] = 1'b0;
        wait_idle();

        // Reset in the middle of a run aborts it with no done.
        av[0] = 8'hA5; bv[0] = 8'h3C; bi[0] = 1'b1; st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        flush_model();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        op8(8'hC3, 8'h3C, 1'b1);

        i1 = 0;
        i2 = 0;
        for (int it = 0; it < 6000 && (i1 < 512 || i2 < 8); it++) begin
            for (int u = 0; u < 3; u++) begin
                av[u] = 8'($urandom);
                bv[u] = 8'($urandom);
                bi[u] = 1'($urandom);
            end
            st[0] = ($urandom_range(0, 2) == 0);
            iss1  = (i1 < 512) && (cyc + 1 >= free_e[1]);
            iss2  = (i2 < 8) && (cyc + 1 >= free_e[2]);
            if (iss1) begin
                av[1] = 8'(i1 >> 5);
                bv[1] = 8'((i1 >> 1) & 15);
                bi[1] = 1'(i1 & 1);
                st[1] = 1'b1;
            end else begin
                st[1] = (i1 < 512) && ($urandom_range(0, 3) == 0);
            end
            if (iss2) begin
                av[2] = 8'(i2 >> 2);
                bv[2] = 8'((i2 >> 1) & 1);
                bi[2] = 1'(i2 & 1);
                st[2] = 1'b1;
            end else begin
                st[2] = 1'b0;
            end
            tick();
            if (iss1 && acc[1]) i1++;
            if (iss2 && acc[2]) i2++;
        end
        st = 3'b000;
        repeat (20) tick();

        chk("exhaustive_w4_issued", 1, i1, 32'd512);
        chk("exhaustive_w1_issued", 2, i2, 32'd8);
        for (int u = 0; u < 3; u++) chk("pending_results", u, qsize(u), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
